// File: rtl/lc3_execute.sv
// LC-3 execute stage: operand forwarding, ALU, address generation and
// writeback control, registered for the memory/writeback stage.
module lc3_execute #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_execute,
  input  logic             flush,
  input  logic [WIDTH-1:0] IR,
  input  logic [WIDTH-1:0] npc_in,
  input  logic [WIDTH-1:0] VSR1,
  input  logic [WIDTH-1:0] VSR2,
  input  logic             wb_en,
  input  logic [2:0]       wb_dr,
  input  logic [WIDTH-1:0] wb_data,
  output logic [2:0]       sr1,
  output logic [2:0]       sr2,
  output logic [WIDTH-1:0] aluout,
  output logic [WIDTH-1:0] pcout,
  output logic [WIDTH-1:0] M_Data,
  output logic [2:0]       dr,
  output logic [1:0]       W_Control,
  output logic             reg_we,
  output logic [1:0]       mem_op,
  output logic             br_taken_req,
  output logic             illegal,
  output logic             valid_out
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  logic [3:0]       op;
  logic             st_op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] imm5;
  logic [WIDTH-1:0] off6;
  logic [WIDTH-1:0] off9;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] pc_rel;
  logic [WIDTH-1:0] base_rel;

  assign op    = IR[15:12];
  assign st_op = (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  assign sr1   = IR[8:6];
  assign sr2   = st_op ? IR[11:9] : IR[2:0];

  // Same-edge register-file writes are not yet visible on VSR1/VSR2
  assign opa = (wb_en && wb_dr == sr1) ? wb_data : VSR1;
  assign opb = (wb_en && wb_dr == sr2) ? wb_data : VSR2;

  assign imm5     = {{(WIDTH-5){IR[4]}}, IR[4:0]};
  assign off6     = {{(WIDTH-6){IR[5]}}, IR[5:0]};
  assign off9     = {{(WIDTH-9){IR[8]}}, IR[8:0]};
  assign alu_b    = IR[5] ? imm5 : opb;
  assign pc_rel   = npc_in + off9;
  assign base_rel = opa + off6;

  always_ff @(posedge clk) begin
    if (rst) begin
      aluout       <= '0;
      pcout        <= '0;
      M_Data       <= '0;
      dr           <= '0;
      W_Control    <= '0;
      reg_we       <= 1'b0;
      mem_op       <= '0;
      br_taken_req <= 1'b0;
      illegal      <= 1'b0;
      valid_out    <= 1'b0;
    end else if (flush) begin
      valid_out    <= 1'b0;
      reg_we       <= 1'b0;
      mem_op       <= '0;
      br_taken_req <= 1'b0;
      illegal      <= 1'b0;
    end else if (enable_execute) begin
      valid_out    <= 1'b1;
      dr           <= IR[11:9];
      reg_we       <= 1'b0;
      mem_op       <= '0;
      br_taken_req <= 1'b0;
      illegal      <= 1'b0;
      unique case (op)
        OP_ADD: begin
          aluout    <= opa + alu_b;
          reg_we    <= 1'b1;
          W_Control <= 2'd0;
        end
        OP_AND: begin
          aluout    <= opa & alu_b;
          reg_we    <= 1'b1;
          W_Control <= 2'd0;
        end
        OP_NOT: begin
          aluout    <= ~opa;
          reg_we    <= 1'b1;
          W_Control <= 2'd0;
        end
        OP_BR: begin
          pcout        <= pc_rel;
          br_taken_req <= 1'b1;
        end
        OP_JMP: begin
          pcout        <= opa;
          br_taken_req <= 1'b1;
        end
        OP_LD, OP_LDI: begin
          pcout     <= pc_rel;
          mem_op    <= (op == OP_LD) ? 2'd1 : 2'd3;
          reg_we    <= 1'b1;
          W_Control <= 2'd1;
        end
        OP_LDR: begin
          pcout     <= base_rel;
          mem_op    <= 2'd1;
          reg_we    <= 1'b1;
          W_Control <= 2'd1;
        end
        OP_ST, OP_STI: begin
          pcout  <= pc_rel;
          M_Data <= opb;
          mem_op <= (op == OP_ST) ? 2'd2 : 2'd3;
        end
        OP_STR: begin
          pcout  <= base_rel;
          M_Data <= opb;
          mem_op <= 2'd2;
        end
        OP_LEA: begin
          pcout     <= pc_rel;
          reg_we    <= 1'b1;
          W_Control <= 2'd2;
        end
        default: illegal <= 1'b1;
      endcase
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lc3_execute.sv
// Directed bench for lc3_execute: per-cycle compare against an
// instruction-level model plus hand-computed literal checks.
module tb_lc3_execute;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_execute = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] IR = '0;
  logic [15:0] npc_in = '0;
  logic [15:0] VSR1 = '0;
  logic [15:0] VSR2 = '0;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_dr = '0;
  logic [15:0] wb_data = '0;
  logic [2:0]  sr1, sr2, dr;
  logic [15:0] aluout, pcout, M_Data;
  logic [1:0]  W_Control, mem_op;
  logic        reg_we, br_taken_req, illegal, valid_out;

  int checks = 0;
  int failures = 0;

  lc3_execute #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .enable_execute(enable_execute), .flush(flush),
    .IR(IR), .npc_in(npc_in), .VSR1(VSR1), .VSR2(VSR2),
    .wb_en(wb_en), .wb_dr(wb_dr), .wb_data(wb_data),
    .sr1(sr1), .sr2(sr2), .aluout(aluout), .pcout(pcout),
    .M_Data(M_Data), .dr(dr), .W_Control(W_Control), .reg_we(reg_we),
    .mem_op(mem_op), .br_taken_req(br_taken_req), .illegal(illegal),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model of the stage outputs
  logic        started = 1'b0;
  logic [15:0] m_alu, m_pc, m_md;
  logic [2:0]  m_dr;
  logic [1:0]  m_wc, m_mop;
  logic        m_we, m_br, m_ill, m_vld;

  function automatic logic [15:0] sx(input int v, input int bits);
    int r;
    r = (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    return 16'(r);
  endfunction

  function automatic bit is_store(input logic [15:0] ir);
    int o;
    o = int'(ir[15:12]);
    return o == 3 || o == 7 || o == 11;
  endfunction

  function automatic logic [2:0] exp_sr2(input logic [15:0] ir);
    return is_store(ir) ? ir[11:9] : ir[2:0];
  endfunction

  always @(posedge clk) begin
    logic [15:0] a, b, bsel;
    int o;
    if (rst) begin
      started = 1'b1;
      {m_alu, m_pc, m_md} = '0;
      m_dr = '0; m_wc = '0; m_mop = '0;
      {m_we, m_br, m_ill, m_vld} = '0;
    end else if (flush) begin
      {m_we, m_br, m_ill, m_vld} = '0;
      m_mop = '0;
    end else if (enable_execute) begin
      a = (wb_en && wb_dr == IR[8:6]) ? wb_data : VSR1;
      b = (wb_en && wb_dr == exp_sr2(IR)) ? wb_data : VSR2;
      bsel = IR[5] ? sx(int'(IR[4:0]), 5) : b;
      o = int'(IR[15:12]);
      m_vld = 1'b1; m_dr = IR[11:9];
      m_we = 1'b0; m_br = 1'b0; m_ill = 1'b0; m_mop = 2'd0;
      if (o == 1 || o == 5 || o == 9) begin
        m_alu = (o == 1) ? 16'(int'(a) + int'(bsel)) :
                (o == 5) ? (a & bsel) : ~a;
        m_we = 1'b1; m_wc = 2'd0;
      end else if (o == 0 || o == 12) begin
        m_pc = (o == 0) ? 16'(int'(npc_in) + int'(sx(int'(IR[8:0]), 9))) : a;
        m_br = 1'b1;
      end else if (o == 2 || o == 10 || o == 6) begin
        m_pc = (o == 6) ? 16'(int'(a) + int'(sx(int'(IR[5:0]), 6)))
                        : 16'(int'(npc_in) + int'(sx(int'(IR[8:0]), 9)));
        m_mop = (o == 10) ? 2'd3 : 2'd1;
        m_we = 1'b1; m_wc = 2'd1;
      end else if (o == 3 || o == 11 || o == 7) begin
        m_pc = (o == 7) ? 16'(int'(a) + int'(sx(int'(IR[5:0]), 6)))
                        : 16'(int'(npc_in) + int'(sx(int'(IR[8:0]), 9)));
        m_md = b;
        m_mop = (o == 11) ? 2'd3 : 2'd2;
      end else if (o == 14) begin
        m_pc = 16'(int'(npc_in) + int'(sx(int'(IR[8:0]), 9)));
        m_we = 1'b1; m_wc = 2'd2;
      end else begin
        m_ill = 1'b1;
      end
    end else begin
      m_vld = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("sr1", 16'(sr1), 16'(IR[8:6]));
      chk("sr2", 16'(sr2), 16'(exp_sr2(IR)));
      chk("aluout", aluout, m_alu);
      chk("pcout", pcout, m_pc);
      chk("M_Data", M_Data, m_md);
      chk("dr", 16'(dr), 16'(m_dr));
      chk("W_Control", 16'(W_Control), 16'(m_wc));
      chk("reg_we", 16'(reg_we), 16'(m_we));
      chk("mem_op", 16'(mem_op), 16'(m_mop));
      chk("br_taken_req", 16'(br_taken_req), 16'(m_br));
      chk("illegal", 16'(illegal), 16'(m_ill));
      chk("valid_out", 16'(valid_out), 16'(m_vld));
    end
  end

  task automatic cyc(input logic r, input logic fl, input logic en,
                     input logic [15:0] ir, input logic [15:0] npc,
                     input logic [15:0] v1, input logic [15:0] v2,
                     input logic we, input logic [2:0] wd,
                     input logic [15:0] wdat);
    rst = r; flush = fl; enable_execute = en; IR = ir; npc_in = npc;
    VSR1 = v1; VSR2 = v2; wb_en = we; wb_dr = wd; wb_data = wdat;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(1, 0, 0, 16'h0000, 16'h0000, 16'h0, 16'h0, 0, 3'd0, 16'h0);
    cyc(1, 0, 0, 16'h0000, 16'h0000, 16'h0, 16'h0, 0, 3'd0, 16'h0);
    chk("lit_rst_alu", aluout, 16'h0000);
    chk("lit_rst_valid", 16'(valid_out), 16'h0);

    // ADD R1, R1, R2 with overflow wrap
    cyc(0, 0, 1, 16'h1242, 16'h3001, 16'h7FFF, 16'h0001, 0, 3'd0, 16'h0);
    chk("lit_add_alu", aluout, 16'h8000);
    chk("lit_add_dr", 16'(dr), 16'h1);
    chk("lit_add_we", 16'(reg_we), 16'h1);
    chk("lit_add_valid", 16'(valid_out), 16'h1);

    // ADD R0, R1, #-16
    cyc(0, 0, 1, 16'h1070, 16'h3002, 16'h0005, 16'h0000, 0, 3'd0, 16'h0);
    chk("lit_addi_alu", aluout, 16'hFFF5);
    chk("lit_addi_dr", 16'(dr), 16'h0);

    // NOT R2, R1
    cyc(0, 0, 1, 16'h947F, 16'h3003, 16'h00FF, 16'h0000, 0, 3'd0, 16'h0);
    chk("lit_not_alu", aluout, 16'hFF00);

    // ADD R3, R2, #1 with R2 written this same edge
    cyc(0, 0, 1, 16'h16A1, 16'h3004, 16'h0003, 16'h0000, 1, 3'd2, 16'h0010);
    chk("lit_fwd_alu", aluout, 16'h0011);

    // AND R4, R1, R5 (register form, forward not matching)
    cyc(0, 0, 1, 16'h5845, 16'h3005, 16'h0F0F, 16'h33CC, 1, 3'd6, 16'hFFFF);
    chk("lit_and_alu", aluout, 16'h030C);

    // LD R4, #2 from npc 0xFFFF wraps
    cyc(0, 0, 1, 16'h2802, 16'hFFFF, 16'h0000, 16'h0000, 0, 3'd0, 16'h0);
    chk("lit_ld_pc", pcout, 16'h0001);
    chk("lit_ld_mop", 16'(mem_op), 16'h1);
    chk("lit_ld_wc", 16'(W_Control), 16'h1);

    // STR R5, R6, #-1
    cyc(0, 0, 1, 16'h7BBF, 16'h3007, 16'h3000, 16'hBEEF, 0, 3'd0, 16'h0);
    chk("lit_str_sr2", 16'(sr2), 16'h5);
    chk("lit_str_pc", pcout, 16'h2FFF);
    chk("lit_str_md", M_Data, 16'hBEEF);
    chk("lit_str_we", 16'(reg_we), 16'h0);
    chk("lit_str_mop", 16'(mem_op), 16'h2);

    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 16'h1242, 16'h1234, 16'h1111, 16'h2222, 0, 3'd0, 16'h0);
      chk("lit_hold_pc", pcout, 16'h2FFF);
      chk("lit_hold_valid", 16'(valid_out), 16'h0);
    end

    // LDR, LDI, STI, LEA, BR, JMP
    cyc(0, 0, 1, 16'h6E7E, 16'h3008, 16'h4000, 16'h0000, 0, 3'd0, 16'h0);
    chk("lit_ldr_pc", pcout, 16'h3FFE);
    cyc(0, 0, 1, 16'hA3FF, 16'h3009, 16'h0000, 16'h0000, 0, 3'd0, 16'h0);
    chk("lit_ldi_pc", pcout, 16'h3008);
    chk("lit_ldi_mop", 16'(mem_op), 16'h3);
    cyc(0, 0, 1, 16'hB610, 16'h300A, 16'h0000, 16'h1357, 1, 3'd3, 16'h2468);
    chk("lit_sti_md", M_Data, 16'h2468);
    chk("lit_sti_mop", 16'(mem_op), 16'h3);
    cyc(0, 0, 1, 16'hE203, 16'h0010, 16'h0000, 16'h0000, 0, 3'd0, 16'h0);
    chk("lit_lea_pc", pcout, 16'h0013);
    chk("lit_lea_wc", 16'(W_Control), 16'h2);
    cyc(0, 0, 1, 16'h0E05, 16'h3000, 16'h0000, 16'h0000, 0, 3'd0, 16'h0);
    chk("lit_br_pc", pcout, 16'h3005);
    chk("lit_br_req", 16'(br_taken_req), 16'h1);
    cyc(0, 0, 1, 16'hC1C0, 16'h3001, 16'h4000, 16'h0000, 0, 3'd0, 16'h0);
    chk("lit_jmp_pc", pcout, 16'h4000);

    // flush wins over enable
    cyc(0, 1, 1, 16'h1242, 16'h3002, 16'h1000, 16'h0001, 0, 3'd0, 16'h0);
    chk("lit_flush_valid", 16'(valid_out), 16'h0);
    chk("lit_flush_we", 16'(reg_we), 16'h0);
    chk("lit_flush_br", 16'(br_taken_req), 16'h0);
    chk("lit_flush_alu", aluout, 16'h030C);

    // TRAP x25
    cyc(0, 0, 1, 16'hF025, 16'h3003, 16'h0000, 16'h0000, 0, 3'd0, 16'h0);
    chk("lit_trap_ill", 16'(illegal), 16'h1);
    chk("lit_trap_we", 16'(reg_we), 16'h0);
    chk("lit_trap_valid", 16'(valid_out), 16'h1);

    cyc(0, 0, 1, 16'h1242, 16'h3004, 16'h0001, 16'h0002, 0, 3'd0, 16'h0);
    // reset on the edge a BR is enabled
    cyc(1, 0, 1, 16'h0E05, 16'h3000, 16'h0000, 16'h0000, 0, 3'd0, 16'h0);
    chk("lit_rst_pc", pcout, 16'h0000);
    chk("lit_rst_alu2", aluout, 16'h0000);
    chk("lit_rst_br", 16'(br_taken_req), 16'h0);
    chk("lit_rst_valid2", 16'(valid_out), 16'h0);

    cyc(0, 0, 0, 16'h0000, 16'h0000, 16'h0, 16'h0, 0, 3'd0, 16'h0);
    cyc(0, 0, 0, 16'h0000, 16'h0000, 16'h0, 16'h0, 0, 3'd0, 16'h0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
